swan_column_loader: RTL and testbench

Upstream feeder for `serial_rho` in the SWAN datapath. It assembles one 32-bit half-block (SIDE_SIZE) from four byte-wide columns (COLUMN_SIZE) arriving over a valid/ready stream. It XORs the assembled word with a 32-bit round subkey and holds the result in a single output register. The output is offered to the rho stage over a valid/ready handshake. Column collection for the next word overlaps with the hold of the current word.

---
 rtl/swan_pkg.sv | 17 +
 rtl/swan_column_loader.sv | 68 ++++++
 tb/tb_swan_column_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/swan_pkg.sv
// Shared SWAN datapath constants, column-state encoding and half-block type.
package swan_pkg;

  localparam int BLOCK_SIZE  = 64;
  localparam int SIDE_SIZE   = BLOCK_SIZE / 2;
  localparam int COLUMN_SIZE = SIDE_SIZE / 4;

  typedef enum logic [1:0] {
    C0 = 2'd0,
    C1 = 2'd1,
    C2 = 2'd2,
    C3 = 2'd3
  } col_state_e;

  typedef logic [0:SIDE_SIZE-1] swan_half_t;

endpackage

// File: rtl/swan_column_loader.sv
// Assembles four byte columns into a half-block, XORs in the round subkey and
// offers the result to serial_rho over a single-slot valid/ready register.
//
// state | meaning
// C0    | waiting for column 0 (most significant byte)
// C1    | waiting for column 1
// C2    | waiting for column 2
// C3    | waiting for column 3; acceptance completes the word
module swan_column_loader #(
  parameter int BLOCK_SIZE  = swan_pkg::BLOCK_SIZE,
  parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int COLUMN_SIZE = SIDE_SIZE / 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [0:COLUMN_SIZE-1] col_in,
  input  logic                   col_valid,
  output logic                   col_ready,
  input  logic [0:SIDE_SIZE-1]   rk,
  output logic [0:SIDE_SIZE-1]   x_out,
  output logic                   x_valid,
  input  logic                   x_ready,
  output logic [1:0]             col_idx
);
  import swan_pkg::*;

  col_state_e                          state;
  logic [0:SIDE_SIZE-COLUMN_SIZE-1]    acc;
  logic                                col_fire;

  // The 4th column may land only if the output slot is free or draining now.
  assign col_ready = !clr && (state != C3 || !x_valid || x_ready);
  assign col_fire  = col_valid && col_ready;
  assign col_idx   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= C0;
      acc     <= '0;
      x_out   <= '0;
      x_valid <= 1'b0;
    end else if (clr) begin
      state   <= C0;
      acc     <= '0;
      x_out   <= '0;
      x_valid <= 1'b0;
    end else begin
      if (x_valid && x_ready) begin
        x_valid <= 1'b0;
      end
      if (col_fire) begin
        case (state)
          C3: begin
            x_out   <= {acc, col_in} ^ rk;
            x_valid <= 1'b1;
            state   <= C0;
          end
          default: begin
            acc[int'(state)*COLUMN_SIZE +: COLUMN_SIZE] <= col_in;
            state <= col_state_e'(state + 2'd1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swan_column_loader.sv
// Scoreboard bench for swan_column_loader: directed scenarios plus a random
// phase, checked against a byte-queue reference model of the column loader.
module tb_swan_column_loader;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [0:7]  col_in;
  logic        col_valid;
  logic        col_ready;
  logic [0:31] rk;
  logic [0:31] x_out;
  logic        x_valid;
  logic        x_ready;
  logic [1:0]  col_idx;

  swan_column_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .col_in    (col_in),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .rk        (rk),
    .x_out     (x_out),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .col_idx   (col_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: bytes gathered so far, whether a word is held, and the
  // queue of words the DUT still owes downstream.
  int          m_cnt   = 0;
  bit          m_valid = 1'b0;
  logic [7:0]  m_bytes [4];
  logic [31:0] exp_q [$];

  always @(posedge clk) begin : model
    bit rdy;
    if (!rst_n) begin
      m_cnt   = 0;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      rdy = !clr && (m_cnt != 3 || !m_valid || x_ready);
      if (clr) begin
        if (m_valid && !x_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        m_cnt   = 0;
        m_valid = 1'b0;
      end else begin
        if (m_valid && x_ready) m_valid = 1'b0;
        if (col_valid && rdy) begin
          m_bytes[m_cnt] = col_in;
          if (m_cnt == 3) begin
            exp_q.push_back({m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]} ^ rk);
            m_valid = 1'b1;
            m_cnt   = 0;
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    if (rst_n) begin
      chk("col_ready", 32'(!clr && (m_cnt != 3 || !m_valid || x_ready)), 32'(col_ready));
      chk("col_idx", 32'(col_idx), 32'(m_cnt));
      chk("x_valid", 32'(x_valid), 32'(m_valid));
      if (x_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL x_out_unexpected: x_valid high with x_out=%h but no word expected", x_out);
        end else begin
          chk("x_out", x_out, exp_q[0]);
          if (x_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic beat(input logic v, input logic [7:0] c, input logic [31:0] k,
                      input logic xr, input logic cl);
    col_valid = v;
    col_in    = c;
    rk        = k;
    x_ready   = xr;
    clr       = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; col_valid = 1'b0; col_in = '0; rk = '0; x_ready = 1'b0;
    #22 rst_n = 1'b1;
    #1;
    chk("rst_x_valid", 32'(x_valid), 32'd0);
    chk("rst_x_out", x_out, 32'h0);
    chk("rst_col_idx", 32'(col_idx), 32'd0);
    chk("rst_col_ready", 32'(col_ready), 32'd1);
    @(posedge clk); #1;

    beat(1, 8'hc8, 32'h0, 1, 0); beat(1, 8'h11, 32'h0, 1, 0);
    beat(1, 8'h0a, 32'h0, 1, 0); beat(1, 8'hf6, 32'h0, 1, 0);
    chk("basic_valid", 32'(x_valid), 32'd1);
    chk("basic_word", x_out, 32'hc8110af6);

    beat(1, 8'hc8, 32'hffffffff, 1, 0); beat(1, 8'h11, 32'hffffffff, 1, 0);
    beat(1, 8'h0a, 32'hffffffff, 1, 0); beat(1, 8'hf6, 32'hffffffff, 1, 0);
    chk("keyxor_word", x_out, 32'h37eef509);

    for (int i = 0; i < 8; i++) begin
      beat(1, 8'(i), 32'h0, 1, 0);
      chk("b2b_valid", 32'(x_valid), 32'(i % 4 == 3));
      chk("b2b_ready", 32'(col_ready), 32'd1);
    end
    chk("b2b_word2", x_out, 32'h04050607);

    beat(1, 8'ha1, 32'h0f0f0f0f, 0, 0);
    beat(1, 8'hb2, 32'h0f0f0f0f, 0, 0);
    beat(1, 8'hc3, 32'h0f0f0f0f, 0, 0);
    chk("bp_hold_word", x_out, 32'h04050607);
    col_valid = 1'b1; col_in = 8'hd4; x_ready = 1'b0;
    #1;
    chk("bp_stall_ready", 32'(col_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_stall_word", x_out, 32'h04050607);
    chk("bp_stall_idx", 32'(col_idx), 32'd3);
    x_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(col_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_new_word", x_out, 32'haebdccdb);
    chk("bp_new_valid", 32'(x_valid), 32'd1);
    chk("bp_new_idx", 32'(col_idx), 32'd0);

    beat(1, 8'h11, 32'h0, 1, 0);
    beat(1, 8'h22, 32'h0, 1, 0);
    chk("clr_pre_idx", 32'(col_idx), 32'd2);
    col_valid = 1'b1; col_in = 8'h33; clr = 1'b1;
    #1;
    chk("clr_ready", 32'(col_ready), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_idx", 32'(col_idx), 32'd0);
    beat(1, 8'h01, 32'h0, 1, 0); beat(1, 8'h02, 32'h0, 1, 0);
    beat(1, 8'h03, 32'h0, 1, 0); beat(1, 8'h04, 32'h0, 1, 0);
    chk("clr_word", x_out, 32'h01020304);

    beat(1, 8'h55, 32'h0, 0, 0);
    chk("arst_pre_valid", 32'(x_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x_valid", 32'(x_valid), 32'd0);
    chk("arst_x_out", x_out, 32'h0);
    chk("arst_col_idx", 32'(col_idx), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    repeat (3000) begin
      beat($urandom_range(0, 3) != 0, 8'($urandom), $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end
    repeat (4) beat(0, 8'h0, 32'h0, 1, 0);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
